ram_burst_ctrl: RTL and testbench
=================================

RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, RAM address width (32 locations).
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle burst request, sampled in IDLE only.
REQ-006 SHALL have port op  input  1  1 = write burst, 0 = read burst.
REQ-007 SHALL have port base_addr  input  ADDR_W  first burst address.
REQ-008 SHALL have port len  input  6  beat count; legal range 1..32.
REQ-009 SHALL have port busy / done / err  output  1 each  burst active / completion pulse / rejected-request pulse.
REQ-010 SHALL have port wr_data, wr_valid / wr_ready  input DATA_W, input 1 / output 1  write stream; beat transfers when both are high.
REQ-011 SHALL have port rd_data, rd_valid / rd_ready  output DATA_W, output 1 / input 1  read stream; beat transfers when both are high.
REQ-012 SHALL have port ram_addr, ram_we, ram_d  output ADDR_W, 1, DATA_W  RAM port; ram_we=1 writes ram_d at ram_addr on the edge.
REQ-013 SHALL have port ram_q  input  DATA_W  RAM read data; valid one cycle after ram_addr is driven with ram_we=0.

Function
REQ-014 SHALL implement states IDLE, WRITE, READ, DONE.
REQ-015 IDLE: start with len 1..32 SHALL latch op, base_addr and len, and go to WRITE (op=1) or READ (op=0) on the next edge.
REQ-016 IDLE: start with len=0 or len>32 SHALL pulse err for exactly one cycle and remain in IDLE.
REQ-017 start SHALL be ignored in WRITE, READ and DONE.
REQ-018 busy SHALL be 1 in WRITE and READ, and 0 in IDLE and DONE.
REQ-019 WRITE: wr_ready SHALL be 1; ram_we = wr_valid, ram_d = wr_data, ram_addr = current address (combinational, same cycle).
REQ-020 WRITE: each accepted beat SHALL advance the address by 1 modulo 32 (31 wraps to 0) and decrement the remaining count.
REQ-021 WRITE: cycles with wr_valid=0 SHALL keep ram_we=0 and leave the address and count unchanged.
REQ-022 WRITE: the edge accepting the last beat SHALL enter DONE.
REQ-023 READ: a RAM read SHALL be issued only when reads remain, no issued read is pending, and (rd_valid=0 or rd_ready=1).
REQ-024 READ: the cycle after an issue SHALL load ram_q into rd_data and set rd_valid=1 on the following edge; peak throughput is one beat per 2 cycles.
REQ-025 READ: rd_data SHALL be held stable while rd_valid=1 and rd_ready=0.
REQ-026 READ: rd_valid SHALL clear on handshake unless a new beat loads on the same edge.
REQ-027 READ: the address SHALL advance modulo 32 per issue; the edge completing the last rd handshake SHALL enter DONE.
REQ-028 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-029 ram_we SHALL be 0 in every state except WRITE beats; wr_ready SHALL be 0 outside WRITE.

Reset
REQ-030 reset_n=0 SHALL immediately force IDLE and clear busy, done, err, wr_ready, rd_valid, rd_data, ram_we, ram_addr, ram_d and all counters to 0.
REQ-031 Reset during a burst SHALL abort it without a done pulse; start is accepted from the first edge after release.

Verification
REQ-032 Bench SHALL cover: write, base=30, len=3, data 0x11/0x22/0x33 back-to-back -> ram_we=1 at addresses 30, 31, 0; done=1 one cycle after the third beat.
REQ-033 Bench SHALL cover: read, base=0, len=2, rd_ready=1, RAM preloaded 0x80/0x7F -> rd_data 0x80 then 0x7F; each rd_valid 2 cycles after its issue.
REQ-034 Bench SHALL cover: read, len=3, rd_ready=0 for 5 cycles after the first rd_valid -> rd_data held, no new issue, all 3 beats delivered in order afterwards.
REQ-035 Bench SHALL cover: start with len=0 and then with len=33 -> one-cycle err pulse each, busy stays 0, ram_we stays 0.
REQ-036 Bench SHALL cover: write, len=4, wr_valid low 2 cycles between beats 2 and 3 -> ram_we=0 and ram_addr frozen during the gap; 4 writes to consecutive addresses.
REQ-037 Bench SHALL cover: reset_n low after 2 of 4 write beats -> all outputs 0 the same cycle, no done; a new burst completes normally after release.

Source files
------------

// File: rtl/ram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_burst_ctrl
// Brief    : Burst controller streaming write/read beats to a single-port,
//            one-cycle-latency RAM with wrapping addresses.
// Revision : 1.0 - initial release
// ============================================================================
module ram_burst_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              op,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [5:0]        len,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_d,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [5:0]        c_MAX_LEN  = 6'd32;
    localparam logic [5:0]        c_LEN_ONE  = 6'd1;
    localparam logic [ADDR_W-1:0] c_ADDR_INC = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [5:0]        r_issue_left;
    logic [5:0]        r_beat_left;
    logic              r_pending;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_err;

    logic w_len_ok;
    logic w_accept;
    logic w_wr_beat;
    logic w_issue;
    logic w_rd_hs;

    assign w_len_ok  = (len != 6'd0) && (len <= c_MAX_LEN);
    assign w_accept  = (r_state == S_IDLE) && start && w_len_ok;
    assign w_wr_beat = (r_state == S_WRITE) && wr_valid;
    // One read in flight at a time; a new issue only when the output slot frees up.
    assign w_issue   = (r_state == S_READ) && (r_issue_left != 6'd0) && !r_pending
                       && (!r_rd_valid || rd_ready);
    assign w_rd_hs   = (r_state == S_READ) && r_rd_valid && rd_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        wr_ready    = 1'b0;
        ram_we      = 1'b0;
        ram_d       = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = op ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                busy     = 1'b1;
                wr_ready = 1'b1;
                ram_we   = wr_valid;
                ram_d    = wr_data;
                if (w_wr_beat && (r_beat_left == c_LEN_ONE)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_READ: begin
                busy = 1'b1;
                if (w_rd_hs && (r_beat_left == c_LEN_ONE)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign ram_addr = r_addr;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign err      = r_err;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_addr       <= '0;
            r_issue_left <= '0;
            r_beat_left  <= '0;
            r_pending    <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_err     <= (r_state == S_IDLE) && start && !w_len_ok;
            r_pending <= w_issue;
            if (w_accept) begin
                r_addr       <= base_addr;
                r_issue_left <= len;
                r_beat_left  <= len;
                r_rd_valid   <= 1'b0;
            end else begin
                if (w_wr_beat || w_issue) begin
                    r_addr <= r_addr + c_ADDR_INC;
                end
                if (w_issue) begin
                    r_issue_left <= r_issue_left - c_LEN_ONE;
                end
                if (w_wr_beat || w_rd_hs) begin
                    r_beat_left <= r_beat_left - c_LEN_ONE;
                end
                // ram_q is valid in the cycle after the issue; capture it into the output slot.
                if (r_pending) begin
                    r_rd_data  <= ram_q;
                    r_rd_valid <= 1'b1;
                end else if (w_rd_hs) begin
                    r_rd_valid <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_burst_ctrl
// Brief    : Scoreboard bench for ram_burst_ctrl with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_burst_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start, op;
    logic [4:0] base_addr;
    logic [5:0] len;
    logic       busy, done, err;
    logic [7:0] wr_data;
    logic       wr_valid, wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid, rd_ready;
    logic [4:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_d, ram_q;

    logic       pl_en;
    logic [4:0] pl_addr;
    logic [7:0] pl_data;
    logic [7:0] mem   [32];
    logic [7:0] model [32];

    logic [12:0] wq[$];
    logic [7:0]  rq[$];
    int          vcycles[$];
    int          rd_done_cyc;
    int          done_cnt = 0;
    int          n_tests  = 0;
    int          n_fail   = 0;

    ram_burst_ctrl #(.ADDR_W(5), .DATA_W(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_d     (ram_d),
        .ram_q     (ram_q)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_we) mem[ram_addr] <= ram_d;
        ram_q <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every RAM write and every read handshake pops an expectation.
    always @(negedge clock) begin
        if (reset_n) begin
            if (done) done_cnt++;
            if (ram_we) begin
                if (wq.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    logic [12:0] e;
                    e = wq.pop_front();
                    check("wr_addr", ram_addr, e[12:8]);
                    check("wr_data", ram_d, e[7:0]);
                end
            end
            if (rd_valid && rd_ready) begin
                if (rq.size() == 0) check("rd_unexpected", 1, 0);
                else check("rd_data", rd_data, rq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic preload(input logic [4:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d; model[a] = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic start_burst(input logic o, input logic [4:0] b, input logic [5:0] n);
        start = 1'b1; op = o; base_addr = b; len = n;
        tick();
        start = 1'b0; len = 6'd0;
    endtask

    task automatic write_burst(input logic [4:0] base, input int n, input logic [7:0] d0,
                               input int step, input int gap_at, input int gap_len);
        logic [4:0] a;
        logic [7:0] dat;
        start_burst(1'b1, base, 6'(n));
        a = base;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                wr_valid = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    start = 1'b1; op = 1'b0; len = 6'd5;
                    @(negedge clock);
                    check("gap_we", ram_we, 0);
                    check("gap_addr", ram_addr, a);
                    check("gap_busy", busy, 1);
                    tick();
                end
                start = 1'b0; len = 6'd0;
            end
            dat = d0 + 8'(step * i);
            wr_valid = 1'b1; wr_data = dat;
            wq.push_back({a, dat});
            model[a] = dat;
            @(negedge clock);
            check("wr_ready", wr_ready, 1);
            tick();
            a = a + 5'd1;
        end
        wr_valid = 1'b0;
        @(negedge clock);
        check("wr_done", done, 1);
        check("wr_done_busy", busy, 0);
        check("wr_q_empty", wq.size(), 0);
        tick();
        check("wr_done_one_cycle", done, 0);
    endtask

    task automatic read_burst(input logic [4:0] base, input int n, input int stall);
        int  cyc, stall_left;
        bit  seen, finished;
        for (int i = 0; i < n; i++) rq.push_back(model[base + 5'(i)]);
        vcycles.delete();
        rd_ready = 1'b1;
        start_burst(1'b0, base, 6'(n));
        cyc = 0; stall_left = 0; seen = 1'b0; finished = 1'b0;
        while (cyc < 200 && !finished) begin
            if (stall > 0 && !seen && rd_valid) begin
                seen = 1'b1; stall_left = stall;
            end
            rd_ready = (stall_left > 0) ? 1'b0 : 1'b1;
            @(negedge clock);
            if (stall_left > 0) begin
                check("rd_hold_valid", rd_valid, 1);
                check("rd_hold_data", rd_data, rq[0]);
                check("rd_no_issue", ram_addr, base + 5'd1);
                stall_left--;
            end
            if (done) begin
                finished = 1'b1;
                rd_done_cyc = cyc;
            end else begin
                if (rd_valid && rd_ready) vcycles.push_back(cyc);
                tick();
                cyc++;
            end
        end
        if (!finished) check("rd_timeout", 0, 1);
        check("rd_q_empty", rq.size(), 0);
        rd_ready = 1'b1;
        tick();
    endtask

    task automatic err_case(input logic [5:0] n);
        int errs;
        errs = 0;
        start = 1'b1; op = 1'b1; len = n;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (err) errs++;
            check("err_busy", busy, 0);
            check("err_we", ram_we, 0);
            tick();
            start = 1'b0;
        end
        check("err_pulse_count", errs, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        reset_n = 1'b0; start = 1'b0; op = 1'b0; base_addr = '0; len = '0;
        wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b1;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (2) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_outs", {wr_ready, rd_valid, ram_we, rd_data, ram_addr, ram_d}, 0);
        reset_n = 1'b1;
        tick();

        // Wrapping write: 30, 31, 0.
        write_burst(5'd30, 3, 8'h11, 8'h11, -1, 0);

        // Back-to-back read with two-cycle issue-to-valid latency.
        preload(5'd0, 8'h80);
        preload(5'd1, 8'h7F);
        read_burst(5'd0, 2, 0);
        check("rd_beats", vcycles.size(), 2);
        if (vcycles.size() == 2) begin
            check("rd_valid0_cyc", vcycles[0], 2);
            check("rd_valid1_cyc", vcycles[1], 4);
        end
        check("rd_done_cyc", rd_done_cyc, 5);

        // Stalled consumer on a wrapping read: 30, 31, 0.
        read_burst(5'd30, 3, 5);
        check("stall_beats", vcycles.size(), 3);

        // Rejected lengths.
        err_case(6'd0);
        err_case(6'd33);

        // Write with a two-cycle producer gap (start pulsed during the gap).
        write_burst(5'd5, 4, 8'hA1, 1, 2, 2);
        read_burst(5'd5, 4, 0);

        // Reset in the middle of a write burst.
        start_burst(1'b1, 5'd10, 6'd4);
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1; wr_data = 8'h50 + 8'(i);
            wq.push_back({5'd10 + 5'(i), wr_data});
            model[5'd10 + 5'(i)] = wr_data;
            tick();
        end
        wr_data = 8'h52;
        d = done_cnt;
        reset_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_err", err, 0);
        check("abort_we", ram_we, 0);
        check("abort_outs", {wr_ready, rd_valid, rd_data, ram_addr, ram_d}, 0);
        wr_valid = 1'b0;
        repeat (2) tick();
        check("abort_q_empty", wq.size(), 0);
        reset_n = 1'b1;
        write_burst(5'd3, 2, 8'h61, 1, -1, 0);
        check("abort_no_done", done_cnt, d + 1);
        read_burst(5'd10, 2, 0);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
